// File: rtl/button_decoder.sv
// Debounces the four arrow push-buttons and turns each clean press into a
// single arrow event held in a one-entry valid/ack register.
module button_decoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_BITS        = 19
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_u,
  input  logic       btn_d,
  input  logic       btn_l,
  input  logic       btn_r,
  input  logic       enable,
  output logic [3:0] held,
  output logic       press_valid,
  output logic [1:0] press_arrow,
  output logic       press_multi,
  input  logic       press_ack,
  output logic       overflow
);

  localparam int unsigned         NBTN     = 4;
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DEBOUNCE_CYCLES - 1);

  logic [NBTN-1:0]     w_raw;
  logic [NBTN-1:0]     r_s1;
  logic [NBTN-1:0]     r_s2;
  logic [NBTN-1:0]     r_stable;
  logic [NBTN-1:0]     r_stable_d;
  logic [CNT_BITS-1:0] r_cnt [NBTN];

  logic [NBTN-1:0]     w_rise;
  logic                w_any_rise;
  logic [1:0]          w_arrow;
  logic                w_multi;

  logic                r_valid;
  logic [1:0]          r_arrow;
  logic                r_multi;
  logic                r_ovf;
  logic                w_valid_nxt;
  logic [1:0]          w_arrow_nxt;
  logic                w_multi_nxt;
  logic                w_ovf_nxt;

  // Bit order matches held: {r,l,d,u}
  assign w_raw = {btn_r, btn_l, btn_d, btn_u};

  // Two-flop synchronizer for the asynchronous pins
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= w_raw;
      r_s2 <= r_s1;
    end
  end

  // Per-button debounce: a level is accepted only after DEBOUNCE_CYCLES
  // consecutive mismatching samples; any bounce back restarts the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stable   <= '0;
      r_stable_d <= '0;
      for (int i = 0; i < NBTN; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_stable_d <= r_stable;
      for (int i = 0; i < NBTN; i++) begin
        if (r_s2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_stable[i] <= r_s2[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_BITS'(1);
        end
      end
    end
  end

  assign w_rise     = r_stable & ~r_stable_d;
  assign w_any_rise = |w_rise;

  // Fixed priority up > down > left > right; lower-priority presses are lost
  always_comb begin
    w_arrow = 2'd3;
    if (w_rise[0]) begin
      w_arrow = 2'd0;
    end else if (w_rise[1]) begin
      w_arrow = 2'd1;
    end else if (w_rise[2]) begin
      w_arrow = 2'd2;
    end
  end

  // Multi: several simultaneous presses, or another button already down
  assign w_multi = ((w_rise & (w_rise - NBTN'(1))) != '0) ||
                   ((r_stable & ~w_rise) != '0);

  // One-entry event register with ack and drop-on-full
  always_comb begin
    w_valid_nxt = r_valid;
    w_arrow_nxt = r_arrow;
    w_multi_nxt = r_multi;
    w_ovf_nxt   = 1'b0;
    if (!enable) begin
      w_valid_nxt = 1'b0;
    end else if (w_any_rise) begin
      if (!r_valid || press_ack) begin
        w_valid_nxt = 1'b1;
        w_arrow_nxt = w_arrow;
        w_multi_nxt = w_multi;
      end else begin
        w_ovf_nxt = 1'b1;
      end
    end else if (r_valid && press_ack) begin
      w_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_arrow <= 2'd0;
      r_multi <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_valid <= w_valid_nxt;
      r_arrow <= w_arrow_nxt;
      r_multi <= w_multi_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  assign held        = r_stable;
  assign press_valid = r_valid;
  assign press_arrow = r_arrow;
  assign press_multi = r_multi;
  assign overflow    = r_ovf;

endmodule

// File: tb/tb_button_decoder.sv
// Directed bench for button_decoder with a short debounce window.
module tb_button_decoder;

  localparam int unsigned DEB = 4;
  localparam int unsigned CB  = 3;

  logic       clk;
  logic       reset;
  logic       btn_u;
  logic       btn_d;
  logic       btn_l;
  logic       btn_r;
  logic       enable;
  logic [3:0] held;
  logic       press_valid;
  logic [1:0] press_arrow;
  logic       press_multi;
  logic       press_ack;
  logic       overflow;

  int n_tests = 0;
  int n_fail  = 0;

  button_decoder #(.DEBOUNCE_CYCLES(DEB), .CNT_BITS(CB)) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_u       (btn_u),
    .btn_d       (btn_d),
    .btn_l       (btn_l),
    .btn_r       (btn_r),
    .enable      (enable),
    .held        (held),
    .press_valid (press_valid),
    .press_arrow (press_arrow),
    .press_multi (press_multi),
    .press_ack   (press_ack),
    .overflow    (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [3:0] btn;
    logic       en;
    logic       ack;
    logic [3:0] held;
    logic       valid;
    logic [1:0] arrow;
    logic       multi;
    logic       ovf;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic [3:0] b, input logic e, input logic a,
                              input logic [3:0] h, input logic v,
                              input logic [1:0] ar, input logic m, input logic o);
    vec_t t;
    t.btn = b; t.en = e; t.ack = a; t.held = h;
    t.valid = v; t.arrow = ar; t.multi = m; t.ovf = o;
    return t;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_btn(input logic [3:0] b);
    {btn_r, btn_l, btn_d, btn_u} = b;
  endtask

  task automatic ack_once();
    press_ack = 1'b1;
    step(1);
    press_ack = 1'b0;
  endtask

  int bad;

  initial begin
    reset = 1'b0; enable = 1'b1; press_ack = 1'b0;
    set_btn(4'b0000);
    step(3);
    chk("reset_state", 16'({held, press_valid, press_arrow, press_multi, overflow}), 16'h0);
    reset = 1'b1;
    step(2);

    // Clean left press, long pending, ack, then release with no event
    for (int i = 0; i < 5; i++) vq.push_back(mk(4'b0100, 1, 0, 4'b0000, 0, 0, 0, 0));
    vq.push_back(mk(4'b0100, 1, 0, 4'b0100, 0, 0, 0, 0));
    for (int i = 0; i < 20; i++) vq.push_back(mk(4'b0100, 1, 0, 4'b0100, 1, 2'd2, 0, 0));
    vq.push_back(mk(4'b0100, 1, 1, 4'b0100, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++) vq.push_back(mk(4'b0000, 1, 0, 4'b0100, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) vq.push_back(mk(4'b0000, 1, 0, 4'b0000, 0, 0, 0, 0));

    foreach (vq[i]) begin
      set_btn(vq[i].btn);
      enable    = vq[i].en;
      press_ack = vq[i].ack;
      step(1);
      chk($sformatf("vec%0d_held_valid_ovf", i),
          16'({held, press_valid, overflow}),
          16'({vq[i].held, vq[i].valid, vq[i].ovf}));
      if (vq[i].valid)
        chk($sformatf("vec%0d_arrow_multi", i),
            16'({press_arrow, press_multi}), 16'({vq[i].arrow, vq[i].multi}));
    end
    press_ack = 1'b0;

    // Bounce on up: never accepted while toggling every two cycles
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      btn_u = ((c % 4) < 2);
      step(1);
      if (press_valid || held != 4'b0000) bad++;
    end
    chk("bounce_quiet", 16'(bad), 16'd0);
    btn_u = 1'b1;
    step(6);
    chk("bounce_not_yet", 16'({held, press_valid}), 16'({4'b0001, 1'b0}));
    step(1);
    chk("bounce_event", 16'({press_valid, press_arrow, press_multi}), 16'({1'b1, 2'd0, 1'b0}));
    ack_once();
    chk("bounce_acked", 16'(press_valid), 16'd0);
    btn_u = 1'b0;
    step(8);
    chk("release_no_event", 16'({held, press_valid}), 16'd0);

    // Down and right together: down wins, flagged multi, single event
    set_btn(4'b1010);
    step(7);
    chk("simul_event", 16'({press_valid, press_arrow, press_multi}), 16'({1'b1, 2'd1, 1'b1}));
    ack_once();
    step(6);
    chk("simul_single", 16'({press_valid, overflow}), 16'd0);
    set_btn(4'b0000);
    step(8);

    // Right held first, then up: up event carries multi
    set_btn(4'b1000);
    step(7);
    chk("right_alone", 16'({press_valid, press_arrow, press_multi}), 16'({1'b1, 2'd3, 1'b0}));
    ack_once();
    set_btn(4'b1001);
    step(7);
    chk("up_over_held_r", 16'({press_valid, press_arrow, press_multi}), 16'({1'b1, 2'd0, 1'b1}));
    ack_once();
    set_btn(4'b0000);
    step(8);

    // Overflow while full, then ack coinciding with a new press
    set_btn(4'b0001);
    step(7);
    chk("ovf_pending", 16'({press_valid, press_arrow}), 16'({1'b1, 2'd0}));
    set_btn(4'b0011);
    step(6);
    chk("ovf_before", 16'(overflow), 16'd0);
    step(1);
    chk("ovf_pulse", 16'({overflow, press_valid, press_arrow, press_multi}),
        16'({1'b1, 1'b1, 2'd0, 1'b0}));
    step(1);
    chk("ovf_after", 16'({overflow, press_valid, press_arrow}), 16'({1'b0, 1'b1, 2'd0}));
    set_btn(4'b0111);
    step(6);
    press_ack = 1'b1;
    step(1);
    press_ack = 1'b0;
    chk("ack_with_new", 16'({press_valid, press_arrow, press_multi, overflow}),
        16'({1'b1, 2'd2, 1'b1, 1'b0}));
    ack_once();
    chk("ack_clear", 16'(press_valid), 16'd0);
    set_btn(4'b0000);
    step(8);

    // Enable gating
    enable = 1'b0;
    set_btn(4'b1000);
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      step(1);
      if (press_valid || overflow) bad++;
    end
    chk("disabled_no_event", 16'(bad), 16'd0);
    chk("disabled_held", 16'(held), 16'(4'b1000));
    set_btn(4'b0000);
    step(8);
    enable = 1'b1;
    set_btn(4'b1000);
    step(7);
    chk("en_event", 16'({press_valid, press_arrow}), 16'({1'b1, 2'd3}));
    enable = 1'b0;
    step(1);
    chk("en_drop_clears", 16'(press_valid), 16'd0);
    enable = 1'b1;

    // Mid-operation reset with event pending and up mid-debounce
    set_btn(4'b1010);
    step(7);
    chk("pre_reset_event", 16'({press_valid, press_arrow, press_multi}), 16'({1'b1, 2'd1, 1'b1}));
    set_btn(4'b1011);
    step(3);
    #2 reset = 1'b0;
    #1 chk("async_reset", 16'({held, press_valid, press_arrow, press_multi, overflow}), 16'h0);
    set_btn(4'b0001);
    step(3);
    reset = 1'b1;
    step(6);
    chk("post_reset_wait", 16'({held, press_valid}), 16'({4'b0001, 1'b0}));
    step(1);
    chk("post_reset_event", 16'({press_valid, press_arrow, press_multi}), 16'({1'b1, 2'd0, 1'b0}));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/button_decoder.md
# button_decoder

Input-side counterpart to the arrow/display path: conditions the four raw directional push-buttons, debounces them and turns each clean press into a single encoded arrow event for the collision logic. It sits between the board pins (btnU/btnD/btnL/btnR) and the hit-detection block, replacing raw level sampling with a valid/ack event interface. Debounced button levels are also exported for LED diagnostics.

## Interface
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a level change (5 ms at 100 MHz); minimum 2.
- CNT_BITS, 19, debounce counter width; must satisfy 2^CNT_BITS > DEBOUNCE_CYCLES.
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- btn_u, btn_d, btn_l, btn_r  input  1 each  raw, asynchronous, active-high buttons.
- enable  input  1  high while the game is in play state; gates event generation only.
- held  output  4  debounced levels {r,l,d,u} (bit 0 = up).
- press_valid  output  1  an event is pending.
- press_arrow  output  2  arrow code of the pending event: 0 up, 1 down, 2 left, 3 right.
- press_multi  output  1  pending event was accompanied by another simultaneous press.
- press_ack  input  1  consumer accepts the pending event this cycle.
- overflow  output  1  one-cycle pulse: an event was dropped.

## Operation
- Per button: two-flop synchronizer (s1, s2), then debounce stage with stable bit and CNT_BITS counter.
- Debounce:
  - If s2 == stable, the counter clears.
  - Otherwise the counter increments.
  - When the counter equals DEBOUNCE_CYCLES-1 while mismatched, stable <= s2 and the counter clears.
  - Any bounce back to the stable value restarts the count from 0.
- held = stable bits.
- Press = 0->1 transition of stable. Releases generate no event.
- Arbitration for presses in the same cycle: priority up > down > left > right.
  - The highest-priority press is encoded; the others are discarded.
  - press_multi = 1 if more than one press occurred in that cycle, or any other held bit was already 1 when the press occurred.
- Event register (one entry):
  - If empty and a press occurs with enable=1: load arrow/multi, set press_valid.
  - If full and press_ack=1: the event is consumed. If a new press occurs in the same cycle, the new press loads and press_valid stays 1; otherwise press_valid clears.
  - If full, press_ack=0 and a new press occurs: the new press is dropped, overflow pulses for 1 cycle, and the pending event is unchanged.
- enable=0:
  - Presses are ignored (no overflow).
  - Any pending event is cleared the next edge.
  - Debouncing and held continue to update.
- press_ack while press_valid=0 is ignored.

## Timing
- Reset (asynchronous, active-low): s1, s2, stable, counters, held, press_valid, press_arrow, press_multi and overflow all go to 0.
- A button held through reset release is seen as a fresh press after debounce.
- Press latency, with raw high first sampled by s1 at edge k and held steady:
  - s2 = 1 at edge k+1.
  - stable = 1 at edge k+DEBOUNCE_CYCLES+1.
  - press_valid = 1 at edge k+DEBOUNCE_CYCLES+2.
- Release latency: held falls at edge k+DEBOUNCE_CYCLES+1, symmetric with press.
- press_valid is a registered level, held until acked or until enable falls. Ack with valid=1 at edge j clears valid at edge j+1.
- overflow is high for exactly the cycle after the dropping edge.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Clean press (DEBOUNCE_CYCLES=4, enable=1): btn_l high from edge 0, ack tied 0. Required: held=4'b0100 at edge 5, press_valid=1 at edge 6 with press_arrow=2 and press_multi=0. Valid stays high for 20 cycles.
- Bounce rejection: btn_u toggles every 2 cycles for 20 cycles, then stays high. Required: no event during toggling; exactly one event (arrow 0) 6 edges after the final steady rise. Release generates no event.
- Simultaneous press: btn_d and btn_r rise in the same cycle. Required: press_arrow=1, press_multi=1, one event only. Second case: btn_r already held, then btn_u pressed → arrow 0, multi=1.
- Handshake/overflow: with an event pending and ack=0, press btn_d → overflow one-cycle pulse, pending arrow unchanged. Then assert ack in the same cycle a new press stable-rises → valid stays 1 with the new arrow.
- enable gating: enable=0 while btn_r is pressed → no press_valid, held=4'b1000. Drop enable with an event pending → press_valid=0 next edge.
- Mid-operation reset: assert reset during a debounce count and with an event pending → all outputs 0 immediately. Release reset with btn_u held → event arrow 0 at DEBOUNCE_CYCLES+2 edges after the first post-reset sampling edge.
